// File: rtl/filter_pkg.sv
// Shared definitions for the 3x3 filter datapath: sequencer state encoding,
// core mode encoding and default core latencies.
package filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_WIN  = 3'd3,
        ST_ISSUE     = 3'd4,
        ST_WAIT_CORE = 3'd5,
        ST_WRITE     = 3'd6,
        ST_DONE      = 3'd7
    } seq_state_e;

    typedef enum logic {
        MODE_SOBEL  = 1'b0,
        MODE_MEDIAN = 1'b1
    } core_mode_e;

    localparam int SOBEL_LAT_DEF  = 2;
    localparam int MEDIAN_LAT_DEF = 4;
    localparam int LAT_CNT_W      = 8;

    // Exactly one core must be selected for a frame to run.
    function automatic logic mode_legal(input logic sel_sobel, input logic sel_median);
        return sel_sobel ^ sel_median;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Row/column/linear-address walker for a raster scan; the linear address is
// kept incrementally so no multiplier is needed.
module raster_counter
    import filter_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [15:0]       row,
    output logic [15:0]       col,
    output logic [ADDR_W-1:0] addr,
    output logic              is_border,
    output logic              is_last
);

    localparam logic [15:0]       LAST_COL = 16'(IMG_W - 1);
    localparam logic [15:0]       LAST_ROW = 16'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [15:0]       row_r;
    logic [15:0]       col_r;
    logic [ADDR_W-1:0] addr_r;

    // Position registers; stepping past the last pixel wraps back to the origin.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            row_r  <= 16'd0;
            col_r  <= 16'd0;
            addr_r <= '0;
        end else if (advance) begin
            if (is_last) begin
                row_r  <= 16'd0;
                col_r  <= 16'd0;
                addr_r <= '0;
            end else if (col_r == LAST_COL) begin
                row_r  <= row_r + 16'd1;
                col_r  <= 16'd0;
                addr_r <= addr_r + ADDR_ONE;
            end else begin
                col_r  <= col_r + 16'd1;
                addr_r <= addr_r + ADDR_ONE;
            end
        end
    end

    assign row       = row_r;
    assign col       = col_r;
    assign addr      = addr_r;
    assign is_border = (row_r == 16'd0) || (row_r == LAST_ROW) ||
                       (col_r == 16'd0) || (col_r == LAST_COL);
    assign is_last   = (row_r == LAST_ROW) && (col_r == LAST_COL);

endmodule

// File: rtl/filter_sequencer.sv
// Raster-scan controller: fetches a 3x3 window per interior pixel, runs the
// selected filter core, and writes one result (or zero for borders) per pixel.
module filter_sequencer
    import filter_pkg::*;
#(
    parameter int IMG_W      = 256,
    parameter int IMG_H      = 256,
    parameter int ADDR_W     = 16,
    parameter int SOBEL_LAT  = SOBEL_LAT_DEF,
    parameter int MEDIAN_LAT = MEDIAN_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sobel,
    input  logic              median,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              win_req,
    output logic [15:0]       win_row,
    output logic [15:0]       win_col,
    input  logic              win_valid,
    output logic              core_sel,
    output logic              core_in_valid,
    input  logic [7:0]        sobel_result,
    input  logic [7:0]        median_result,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        bus_out,
    input  logic              out_ready
);

    localparam logic [LAT_CNT_W-1:0] SOBEL_CNT  = LAT_CNT_W'(SOBEL_LAT);
    localparam logic [LAT_CNT_W-1:0] MEDIAN_CNT = LAT_CNT_W'(MEDIAN_LAT);
    localparam logic [LAT_CNT_W-1:0] CNT_ONE    = {{(LAT_CNT_W-1){1'b0}}, 1'b1};

    seq_state_e             state_r;
    seq_state_e             next_state_s;
    core_mode_e             core_sel_r;
    logic [LAT_CNT_W-1:0]   lat_cnt_r;
    logic                   busy_r, done_r, err_r, win_req_r, core_in_valid_r, mem_write_en_r;
    logic [15:0]            win_row_r, win_col_r;
    logic [7:0]             bus_out_r;
    logic [15:0]            row_s, col_s;
    logic [ADDR_W-1:0]      addr_s;
    logic                   is_border_s, is_last_s;
    logic                   legal_s, advance_s, clear_s, lat_done_s;

    assign legal_s    = mode_legal(sobel, median);
    assign advance_s  = (state_r == ST_WRITE) && out_ready;
    assign clear_s    = (state_r == ST_IDLE) && start && legal_s;
    // The counter holds LAT on entry; its step to zero is the capture cycle.
    assign lat_done_s = (lat_cnt_r == CNT_ONE);

    raster_counter #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear_s),
        .advance   (advance_s),
        .row       (row_s),
        .col       (col_s),
        .addr      (addr_s),
        .is_border (is_border_s),
        .is_last   (is_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = legal_s ? ST_CHECK : ST_DONE;
                else       next_state_s = ST_IDLE;
            end
            ST_CHECK:     next_state_s = is_border_s ? ST_WRITE : ST_REQ;
            ST_REQ:       next_state_s = ST_WAIT_WIN;
            ST_WAIT_WIN: begin
                if (win_valid) next_state_s = ST_ISSUE;
                else           next_state_s = ST_WAIT_WIN;
            end
            ST_ISSUE:     next_state_s = ST_WAIT_CORE;
            ST_WAIT_CORE: begin
                if (lat_done_s) next_state_s = ST_WRITE;
                else            next_state_s = ST_WAIT_CORE;
            end
            ST_WRITE: begin
                if (out_ready) next_state_s = is_last_s ? ST_DONE : ST_CHECK;
                else           next_state_s = ST_WRITE;
            end
            ST_DONE:      next_state_s = ST_IDLE;
            default:      next_state_s = ST_IDLE;
        endcase
    end

    // Status strobes are registered from the upcoming state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            win_req_r       <= 1'b0;
            core_in_valid_r <= 1'b0;
            mem_write_en_r  <= 1'b0;
        end else begin
            busy_r          <= (next_state_s != ST_IDLE);
            done_r          <= (next_state_s == ST_DONE);
            win_req_r       <= (next_state_s == ST_REQ);
            core_in_valid_r <= (next_state_s == ST_ISSUE);
            mem_write_en_r  <= (next_state_s == ST_WRITE);
        end
    end

    // Frame mode, error flag, window address, latency counter and write data.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_sel_r <= MODE_SOBEL;
            err_r      <= 1'b0;
            win_row_r  <= 16'd0;
            win_col_r  <= 16'd0;
            lat_cnt_r  <= '0;
            bus_out_r  <= 8'd0;
        end else begin
            if (clear_s) begin
                core_sel_r <= median ? MODE_MEDIAN : MODE_SOBEL;
                err_r      <= 1'b0;
            end else if ((state_r == ST_IDLE) && start) begin
                err_r      <= 1'b1;
            end
            if (next_state_s == ST_REQ) begin
                win_row_r <= row_s;
                win_col_r <= col_s;
            end
            if (state_r == ST_ISSUE) begin
                lat_cnt_r <= (core_sel_r == MODE_MEDIAN) ? MEDIAN_CNT : SOBEL_CNT;
            end else if (state_r == ST_WAIT_CORE) begin
                lat_cnt_r <= lat_cnt_r - CNT_ONE;
            end
            if ((state_r == ST_CHECK) && is_border_s) begin
                bus_out_r <= 8'd0;
            end else if ((state_r == ST_WAIT_CORE) && lat_done_s) begin
                bus_out_r <= (core_sel_r == MODE_MEDIAN) ? median_result : sobel_result;
            end
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign win_req       = win_req_r;
    assign win_row       = win_row_r;
    assign win_col       = win_col_r;
    assign core_sel      = core_sel_r;
    assign core_in_valid = core_in_valid_r;
    assign mem_write_en  = mem_write_en_r;
    assign wr_addr       = addr_s;
    assign bus_out       = bus_out_r;

endmodule
